// File: rtl/avalon_multi_timer.sv
// avalon_multi_timer
//   Multi-channel interval timer on a 32-bit Avalon-MM slave. Each channel has
//   a down-counter behind its own prescaler. A channel runs either one-shot or
//   continuously, and has a snapshot register and a sticky timeout flag (TO).
//   All channels share one level-sensitive interrupt line.
//
//   Register map, word addressed. Channel c occupies words 4c..4c+3:
//     +0 STATUS   bit0 TO (any write clears it), bit1 RUN
//     +1 CONTROL  bit0 ITO, bit1 CONT, bit2 START, bit3 STOP,
//                 bits[8+PRESC_W-1:8] PRESC
//     +2 PERIOD   a write force-reloads the counter on the next cycle and
//                 stops the channel
//     +3 SNAP     a write captures the live counter; a read returns the capture
//   Word 4*NUM_CH is IRQ_PEND, bit c = TO_c & ITO_c.
//   Every other word reads 0, and writes to it are ignored.
//
// Ports
//   clk         system clock
//   reset_n     asynchronous, active-low reset
//   chipselect  slave select
//   write_n     active-low write strobe, qualified by chipselect
//   read_n      active-low read strobe, qualified by chipselect
//   address     word address
//   writedata   write data
//   readdata    registered read data, one cycle of latency
//   irq         OR over all channels of (TO & ITO)
module avalon_multi_timer #(
  parameter int NUM_CH       = 4,
  parameter int CNT_W        = 32,
  parameter int PRESC_W      = 8,
  parameter int RESET_PERIOD = 49999,
  parameter int ADDR_W       = 5
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              chipselect,
  input  logic              write_n,
  input  logic              read_n,
  input  logic [ADDR_W-1:0] address,
  input  logic [31:0]       writedata,
  output logic [31:0]       readdata,
  output logic              irq
);

  localparam logic [CNT_W-1:0]  RST_PERIOD = CNT_W'(RESET_PERIOD);
  localparam logic [ADDR_W-1:0] PEND_ADDR  = ADDR_W'(NUM_CH * 4);

  logic                w_wr;
  logic                w_rd;
  logic [ADDR_W-3:0]   w_ch_idx;
  logic [NUM_CH-1:0]   w_to;
  logic [NUM_CH-1:0]   w_run;
  logic [NUM_CH-1:0]   w_ito;
  logic [NUM_CH-1:0]   w_cont;
  logic [NUM_CH-1:0]   w_pend;
  logic [PRESC_W-1:0]  w_presc  [NUM_CH];
  logic [CNT_W-1:0]    w_period [NUM_CH];
  logic [CNT_W-1:0]    w_snap   [NUM_CH];
  logic [31:0]         w_rdata;
  logic [31:0]         r_readdata;
  logic                w_unused_wdata;

  assign w_wr     = chipselect & ~write_n;
  assign w_rd     = chipselect & ~read_n;
  assign w_ch_idx = address[ADDR_W-1:2];

  // Some writedata bits are never stored, depending on the field widths.
  assign w_unused_wdata = &{1'b0, writedata};

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
      logic               r_to;
      logic               r_run;
      logic               r_ito;
      logic               r_cont;
      logic               r_reload;
      logic [PRESC_W-1:0] r_presc;
      logic [PRESC_W-1:0] r_p;
      logic [CNT_W-1:0]   r_period;
      logic [CNT_W-1:0]   r_count;
      logic [CNT_W-1:0]   r_snap;

      logic w_sel;
      logic w_wr_status;
      logic w_wr_ctrl;
      logic w_wr_period;
      logic w_wr_snap;
      logic w_tick;
      logic w_timeout;

      // A channel index that matches gi always lies below 4*NUM_CH.
      // IRQ_PEND and the unmapped words can never select a channel.
      assign w_sel       = w_wr & (w_ch_idx == (ADDR_W-2)'(gi));
      assign w_wr_status = w_sel & (address[1:0] == 2'd0);
      assign w_wr_ctrl   = w_sel & (address[1:0] == 2'd1);
      assign w_wr_period = w_sel & (address[1:0] == 2'd2);
      assign w_wr_snap   = w_sel & (address[1:0] == 2'd3);

      // The force-reload cycle after a PERIOD write overrides any tick.
      assign w_tick    = r_run & (r_p == r_presc) & ~r_reload;
      assign w_timeout = w_tick & (r_count == '0);

      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          r_to     <= 1'b0;
          r_run    <= 1'b0;
          r_ito    <= 1'b0;
          r_cont   <= 1'b0;
          r_reload <= 1'b0;
          r_presc  <= '0;
          r_p      <= '0;
          r_period <= RST_PERIOD;
          r_count  <= RST_PERIOD;
          r_snap   <= '0;
        end else begin
          // A PERIOD write is stored at once. The counter, prescaler and RUN
          // are forced one cycle later, so a tick in the write cycle still
          // takes effect first.
          r_reload <= w_wr_period;
          if (w_wr_period) begin
            r_period <= writedata[CNT_W-1:0];
          end
          if (w_wr_ctrl) begin
            r_ito   <= writedata[0];
            r_cont  <= writedata[1];
            r_presc <= writedata[8 +: PRESC_W];
          end
          // Captures the count as it was before this edge's update.
          if (w_wr_snap) begin
            r_snap <= r_count;
          end

          if (r_reload) begin
            r_count <= r_period;
            r_p     <= '0;
          end else if (w_tick) begin
            r_p     <= '0;
            r_count <= w_timeout ? r_period : r_count - CNT_W'(1);
          end else if (r_run) begin
            r_p <= r_p + PRESC_W'(1);
          end

          // START beats STOP. Both beat the reload and one-shot clears.
          if (w_wr_ctrl && writedata[2]) begin
            r_run <= 1'b1;
          end else if (w_wr_ctrl && writedata[3]) begin
            r_run <= 1'b0;
          end else if (r_reload) begin
            r_run <= 1'b0;
          end else if (w_timeout && !r_cont) begin
            r_run <= 1'b0;
          end

          // A timeout wins over a simultaneous STATUS write.
          if (w_timeout) begin
            r_to <= 1'b1;
          end else if (w_wr_status) begin
            r_to <= 1'b0;
          end
        end
      end

      assign w_to[gi]     = r_to;
      assign w_run[gi]    = r_run;
      assign w_ito[gi]    = r_ito;
      assign w_cont[gi]   = r_cont;
      assign w_presc[gi]  = r_presc;
      assign w_period[gi] = r_period;
      assign w_snap[gi]   = r_snap;
    end
  endgenerate

  assign w_pend = w_to & w_ito;

  // irq is combinational from registered state, so the asynchronous reset
  // drops it without a clock.
  assign irq = |w_pend;

  always_comb begin
    w_rdata = '0;
    if (address == PEND_ADDR) begin
      w_rdata[NUM_CH-1:0] = w_pend;
    end
    for (int c = 0; c < NUM_CH; c++) begin
      if (w_ch_idx == (ADDR_W-2)'(c)) begin
        case (address[1:0])
          2'd0: w_rdata[1:0] = {w_run[c], w_to[c]};
          2'd1: begin
            w_rdata[0]            = w_ito[c];
            w_rdata[1]            = w_cont[c];
            w_rdata[8 +: PRESC_W] = w_presc[c];
          end
          2'd2: w_rdata[CNT_W-1:0] = w_period[c];
          default: w_rdata[CNT_W-1:0] = w_snap[c];
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_readdata <= '0;
    end else if (w_rd) begin
      r_readdata <= w_rdata;
    end
  end

  assign readdata = r_readdata;

endmodule

// File: tb/tb_avalon_multi_timer.sv
// Self-checking bench for avalon_multi_timer.
// Instance A uses the default parameters. Instance B uses NUM_CH=1, CNT_W=8
// and PRESC_W=1. Both instances share the clock and the reset.
// Bus operations start on a falling edge and last exactly one clock.
module tb_avalon_multi_timer;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;

  logic        a_cs = 1'b0, a_wn = 1'b1, a_rn = 1'b1, a_irq;
  logic [4:0]  a_addr = '0;
  logic [31:0] a_wd = '0, a_rd;

  logic        b_cs = 1'b0, b_wn = 1'b1, b_rn = 1'b1, b_irq;
  logic [2:0]  b_addr = '0;
  logic [31:0] b_wd = '0, b_rd;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  avalon_multi_timer #(
    .NUM_CH(4), .CNT_W(32), .PRESC_W(8), .RESET_PERIOD(49999), .ADDR_W(5)
  ) dut_a (
    .clk(clk), .reset_n(reset_n), .chipselect(a_cs), .write_n(a_wn),
    .read_n(a_rn), .address(a_addr), .writedata(a_wd), .readdata(a_rd),
    .irq(a_irq)
  );

  avalon_multi_timer #(
    .NUM_CH(1), .CNT_W(8), .PRESC_W(1), .RESET_PERIOD(49999), .ADDR_W(3)
  ) dut_b (
    .clk(clk), .reset_n(reset_n), .chipselect(b_cs), .write_n(b_wn),
    .read_n(b_rn), .address(b_addr), .writedata(b_wd), .readdata(b_rd),
    .irq(b_irq)
  );

  typedef struct {
    int          dut;
    bit          rd;
    logic [7:0]  addr;
    logic [31:0] data;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[$];
  localparam int N_RESET_VECS = 12;

  task automatic add(input int d, input bit rd, input logic [7:0] a,
                     input logic [31:0] wd, input logic [31:0] ex);
    vec_t v;
    v.dut = d; v.rd = rd; v.addr = a; v.data = wd; v.exp = ex;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
    end else begin
      $display("ok   %s: 0x%08h", name, got);
    end
  endtask

  task automatic bus_wr(input int d, input logic [7:0] addr, input logic [31:0] data);
    if (d == 0) begin
      a_cs = 1'b1; a_wn = 1'b0; a_addr = addr[4:0]; a_wd = data;
    end else begin
      b_cs = 1'b1; b_wn = 1'b0; b_addr = addr[2:0]; b_wd = data;
    end
    @(negedge clk);
    a_cs = 1'b0; a_wn = 1'b1; b_cs = 1'b0; b_wn = 1'b1;
    $display("wr   dut%0d addr %0d data 0x%08h", d, addr, data);
  endtask

  task automatic bus_rd(input int d, input logic [7:0] addr, output logic [31:0] data);
    if (d == 0) begin
      a_cs = 1'b1; a_rn = 1'b0; a_addr = addr[4:0];
    end else begin
      b_cs = 1'b1; b_rn = 1'b0; b_addr = addr[2:0];
    end
    @(negedge clk);
    a_cs = 1'b0; a_rn = 1'b1; b_cs = 1'b0; b_rn = 1'b1;
    data = (d == 0) ? a_rd : b_rd;
  endtask

  task automatic rd_chk(input string name, input int d, input logic [7:0] addr,
                        input logic [31:0] exp);
    logic [31:0] got;
    bus_rd(d, addr, got);
    chk(name, got, exp);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Counts falling edges until irq is high, giving up at the budget.
  task automatic wait_irq(input int d, input int budget, output int n);
    n = 0;
    while ((((d == 0) ? a_irq : b_irq) == 1'b0) && (n < budget)) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic run_vec(input int i);
    logic [31:0] got;
    if (vecs[i].rd) begin
      bus_rd(vecs[i].dut, vecs[i].addr, got);
      chk($sformatf("vec%0d dut%0d addr%0d", i, vecs[i].dut, vecs[i].addr), got, vecs[i].exp);
    end else begin
      bus_wr(vecs[i].dut, vecs[i].addr, vecs[i].data);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int hits;

    // Reset values. This group is replayed after the mid-run reset.
    add(0, 1, 0,  0, 32'd0);        // ch0 STATUS
    add(0, 1, 1,  0, 32'd0);        // ch0 CONTROL
    add(0, 1, 2,  0, 32'd49999);    // ch0 PERIOD
    add(0, 1, 3,  0, 32'd0);        // ch0 SNAP
    add(0, 1, 16, 0, 32'd0);        // IRQ_PEND
    add(0, 1, 4,  0, 32'd0);        // ch1 STATUS
    add(0, 1, 13, 0, 32'd0);        // ch3 CONTROL
    add(0, 1, 14, 0, 32'd49999);    // ch3 PERIOD
    add(1, 1, 0,  0, 32'd0);        // B STATUS
    add(1, 1, 1,  0, 32'd0);        // B CONTROL
    add(1, 1, 2,  0, 32'd79);       // B PERIOD = 49999 mod 256
    add(1, 1, 4,  0, 32'd0);        // B IRQ_PEND
    // Unmapped words, field masking, START/STOP handling.
    add(0, 0, 20, 32'hFFFF_FFFF, 0);
    add(0, 1, 20, 0, 32'd0);
    add(0, 1, 17, 0, 32'd0);
    add(0, 0, 13, 32'hFFFF_5A0B, 0); // ITO|CONT|STOP, PRESC=0x5A
    add(0, 1, 13, 0, 32'h0000_5A03);
    add(0, 1, 12, 0, 32'd0);         // not running
    add(0, 0, 13, 32'd0, 0);
    add(0, 1, 13, 0, 32'd0);
    add(1, 0, 5,  32'hFFFF_FFFF, 0);
    add(1, 1, 5,  0, 32'd0);
    add(1, 0, 2,  32'h0000_0302, 0); // truncated to 8 bits
    add(1, 1, 2,  0, 32'd2);
    add(1, 0, 1,  32'hFFFF_FFFE, 0); // CONT|START|STOP|PRESC=1
    add(1, 1, 1,  0, 32'h0000_0102);
    add(1, 1, 0,  0, 32'h2);         // START won
    add(1, 0, 1,  32'h8, 0);
    add(1, 1, 0,  0, 32'h0);

    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    chk("irq_after_reset_a", {31'd0, a_irq}, 32'd0);

    for (int i = 0; i < vecs.size(); i++) run_vec(i);

    // ch1: continuous mode, PERIOD=9, PRESC=0
    bus_wr(0, 6, 32'd9);
    idle(1);
    bus_wr(0, 5, 32'h7);
    wait_irq(0, 30, n);
    chk("ch1_first_irq_cycles", n, 32'd10);
    bus_wr(0, 4, 32'd0);
    chk("ch1_irq_cleared", {31'd0, a_irq}, 32'd0);
    wait_irq(0, 30, n);
    chk("ch1_next_irq_cycles", n, 32'd9);
    rd_chk("ch1_irq_pend", 0, 16, 32'h2);
    bus_wr(0, 5, 32'h8);
    bus_wr(0, 4, 32'd0);
    rd_chk("ch1_pend_clear", 0, 16, 32'h0);

    // ch2: one-shot, PERIOD=3, PRESC=4
    bus_wr(0, 10, 32'd3);
    idle(1);
    bus_wr(0, 9, 32'h405);
    wait_irq(0, 40, n);
    chk("ch2_oneshot_cycles", n, 32'd20);
    rd_chk("ch2_status_after", 0, 8, 32'h1);
    bus_wr(0, 11, 32'd0);
    rd_chk("ch2_count_reloaded", 0, 11, 32'd3);
    bus_wr(0, 8, 32'd0);
    hits = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (a_irq) hits++;
    end
    chk("ch2_no_second_timeout", hits, 32'd0);
    rd_chk("ch2_status_idle", 0, 8, 32'h0);
    bus_wr(0, 9, 32'h0);

    // ch0: snapshot, stop, resume
    bus_wr(0, 2, 32'd1000);
    idle(1);
    bus_wr(0, 1, 32'h4);
    idle(100);
    bus_wr(0, 3, 32'd0);
    rd_chk("ch0_snap_running", 0, 3, 32'd900);
    bus_wr(0, 1, 32'h8);
    idle(20);
    bus_wr(0, 3, 32'd0);
    rd_chk("ch0_snap_stopped", 0, 3, 32'd897);
    bus_wr(0, 1, 32'h4);
    idle(10);
    bus_wr(0, 3, 32'd0);
    rd_chk("ch0_snap_resumed", 0, 3, 32'd887);

    // ch0: PERIOD write while running, then START|STOP
    bus_wr(0, 2, 32'd50);
    idle(1);
    rd_chk("ch0_period_wr_stops", 0, 0, 32'h0);
    bus_wr(0, 3, 32'd0);
    rd_chk("ch0_period_wr_loads", 0, 3, 32'd50);
    idle(5);
    bus_wr(0, 3, 32'd0);
    rd_chk("ch0_held_after_reload", 0, 3, 32'd50);
    bus_wr(0, 1, 32'hC);
    rd_chk("ch0_start_stop_runs", 0, 0, 32'h2);
    bus_wr(0, 1, 32'h8);

    // ch3: STATUS write coincident with a timeout
    bus_wr(0, 14, 32'd4);
    idle(1);
    bus_wr(0, 13, 32'h6);
    idle(4);
    bus_wr(0, 12, 32'd0);
    rd_chk("ch3_set_wins", 0, 12, 32'h3);
    bus_wr(0, 12, 32'd0);
    rd_chk("ch3_clear_alone", 0, 12, 32'h2);
    bus_wr(0, 13, 32'h8);
    bus_wr(0, 12, 32'd0);

    // ch3: PERIOD=0 in continuous mode with PRESC=1 times out on every tick
    bus_wr(0, 14, 32'd0);
    idle(1);
    bus_wr(0, 13, 32'h107);
    @(negedge clk);
    chk("ch3_p0_no_tick_yet", {31'd0, a_irq}, 32'd0);
    @(negedge clk);
    chk("ch3_p0_first_tick", {31'd0, a_irq}, 32'd1);
    bus_wr(0, 12, 32'd0);
    chk("ch3_p0_cleared", {31'd0, a_irq}, 32'd0);
    @(negedge clk);
    chk("ch3_p0_next_tick", {31'd0, a_irq}, 32'd1);

    // B: PERIOD=2, PRESC=1 gives a timeout every 6 cycles
    bus_wr(1, 2, 32'd2);
    idle(1);
    bus_wr(1, 1, 32'h107);
    wait_irq(1, 20, n);
    chk("b_irq_cycles", n, 32'd6);
    rd_chk("b_irq_pend", 1, 4, 32'h1);

    // Asynchronous reset in the middle of a cycle, with both instances running
    rd_chk("a_rd_before_reset", 0, 2, 32'd50);
    rd_chk("b_rd_before_reset", 1, 2, 32'd2);
    chk("a_irq_before_reset", {31'd0, a_irq}, 32'd1);
    chk("b_irq_before_reset", {31'd0, b_irq}, 32'd1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("a_irq_async_reset", {31'd0, a_irq}, 32'd0);
    chk("b_irq_async_reset", {31'd0, b_irq}, 32'd0);
    chk("a_readdata_async_reset", a_rd, 32'd0);
    chk("b_readdata_async_reset", b_rd, 32'd0);
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < N_RESET_VECS; i++) run_vec(i);
    idle(30);
    chk("a_irq_stays_low", {31'd0, a_irq}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
